// File: rtl/decode_pipe.sv
// decode_pipe: registered MIPS-I decode stage. It reads the register file,
// forwards operands from EX/MEM, stalls on load-use (or on any RAW hazard
// when forwarding is disabled) and resolves branches and jumps in the stage.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_RUN   | normal operation, instructions accepted and issued
//   S_STALL | RAW hazard, instruction held in IF, bubbles issued
//   S_FLUSH | taken branch without delay slot, next accepted slot dropped
module decode_pipe #(
  parameter int DELAY_SLOT = 1,
  parameter int FWD_EN     = 1,
  parameter int LINK_REG   = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_inst,
  input  logic [31:0] if_pc,
  output logic        id_ready,
  output logic [4:0]  reg1_addr,
  output logic [4:0]  reg2_addr,
  input  logic [31:0] reg1_data,
  input  logic [31:0] reg2_data,
  input  logic        ex_fwd_wreg,
  input  logic        ex_fwd_load,
  input  logic [4:0]  ex_fwd_addr,
  input  logic [31:0] ex_fwd_data,
  input  logic        mem_fwd_wreg,
  input  logic [4:0]  mem_fwd_addr,
  input  logic [31:0] mem_fwd_data,
  input  logic        ex_ready,
  output logic        ex_valid,
  output logic [3:0]  ex_alu_op,
  output logic [31:0] ex_op_a,
  output logic [31:0] ex_op_b,
  output logic        ex_wreg,
  output logic [4:0]  ex_wraddr,
  output logic        ex_mem_rd,
  output logic        ex_mem_wr,
  output logic        ex_mem_byte,
  output logic [31:0] ex_store_data,
  output logic        ex_illegal,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_NOR   = 4'd5;
  localparam logic [3:0] ALU_SLT   = 4'd6;
  localparam logic [3:0] ALU_SLTU  = 4'd7;
  localparam logic [3:0] ALU_SLL   = 4'd8;
  localparam logic [3:0] ALU_SRL   = 4'd9;
  localparam logic [3:0] ALU_SRA   = 4'd10;
  localparam logic [3:0] ALU_PASSB = 4'd11;

  localparam logic [4:0] LINK_ADDR = LINK_REG[4:0];

  typedef enum logic [1:0] {S_RUN, S_STALL, S_FLUSH} state_t;
  state_t state;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [31:0] imm_s, imm_z, pc4, pc8;
  logic [31:0] rs_val, rt_val;

  assign opcode = if_inst[31:26];
  assign rs     = if_inst[25:21];
  assign rt     = if_inst[20:16];
  assign rd     = if_inst[15:11];
  assign shamt  = if_inst[10:6];
  assign funct  = if_inst[5:0];
  assign imm    = if_inst[15:0];
  assign imm_s  = {{16{imm[15]}}, imm};
  assign imm_z  = {16'h0000, imm};
  assign pc4    = if_pc + 32'd4;
  assign pc8    = if_pc + 32'd8;

  assign reg1_addr = rs;
  assign reg2_addr = rt;

  // Operand source: $0 is hard zero, then EX (non-load), MEM, register file.
  function automatic logic [31:0] pick(input logic [4:0] a, input logic [31:0] rf);
    if (a == 5'd0)
      return 32'd0;
    else if (FWD_EN != 0 && ex_fwd_wreg && !ex_fwd_load && ex_fwd_addr == a)
      return ex_fwd_data;
    else if (FWD_EN != 0 && mem_fwd_wreg && mem_fwd_addr == a)
      return mem_fwd_data;
    else
      return rf;
  endfunction

  assign rs_val = pick(rs, reg1_data);
  assign rt_val = pick(rt, reg2_data);

  logic [3:0]  d_alu;
  logic [31:0] d_op_a, d_op_b, br_target;
  logic        d_wreg, d_mem_rd, d_mem_wr, d_mem_byte, d_illegal;
  logic [4:0]  d_wraddr;
  logic        uses_rs, uses_rt, br_taken;

  // Instruction decode, operand substitution and branch resolution.
  always_comb begin
    d_alu      = ALU_ADD;
    d_op_a     = rs_val;
    d_op_b     = rt_val;
    d_wreg     = 1'b0;
    d_wraddr   = rd;
    d_mem_rd   = 1'b0;
    d_mem_wr   = 1'b0;
    d_mem_byte = 1'b0;
    d_illegal  = 1'b0;
    uses_rs    = 1'b0;
    uses_rt    = 1'b0;
    br_taken   = 1'b0;
    br_target  = pc4 + {imm_s[29:0], 2'b00};
    case (opcode)
      6'h00: begin
        d_wreg  = 1'b1;
        uses_rs = 1'b1;
        uses_rt = 1'b1;
        case (funct)
          6'h20, 6'h21: d_alu = ALU_ADD;
          6'h22, 6'h23: d_alu = ALU_SUB;
          6'h24: d_alu = ALU_AND;
          6'h25: d_alu = ALU_OR;
          6'h26: d_alu = ALU_XOR;
          6'h27: d_alu = ALU_NOR;
          6'h2A: d_alu = ALU_SLT;
          6'h2B: d_alu = ALU_SLTU;
          6'h00, 6'h02, 6'h03: begin
            d_alu   = (funct == 6'h00) ? ALU_SLL : (funct == 6'h02) ? ALU_SRL : ALU_SRA;
            d_op_a  = {27'd0, shamt};
            uses_rs = 1'b0;
          end
          6'h04, 6'h06, 6'h07: begin
            d_alu  = (funct == 6'h04) ? ALU_SLL : (funct == 6'h06) ? ALU_SRL : ALU_SRA;
            d_op_a = {27'd0, rs_val[4:0]};
          end
          6'h08: begin
            d_wreg    = 1'b0;
            uses_rt   = 1'b0;
            br_taken  = 1'b1;
            br_target = rs_val;
          end
          default: begin
            d_wreg    = 1'b0;
            uses_rs   = 1'b0;
            uses_rt   = 1'b0;
            d_illegal = 1'b1;
          end
        endcase
      end
      6'h08, 6'h09, 6'h0A, 6'h0B: begin
        d_alu    = (opcode == 6'h0A) ? ALU_SLT : (opcode == 6'h0B) ? ALU_SLTU : ALU_ADD;
        d_op_b   = imm_s;
        d_wreg   = 1'b1;
        d_wraddr = rt;
        uses_rs  = 1'b1;
      end
      6'h0C, 6'h0D, 6'h0E: begin
        d_alu    = (opcode == 6'h0C) ? ALU_AND : (opcode == 6'h0D) ? ALU_OR : ALU_XOR;
        d_op_b   = imm_z;
        d_wreg   = 1'b1;
        d_wraddr = rt;
        uses_rs  = 1'b1;
      end
      6'h0F: begin
        d_alu    = ALU_PASSB;
        d_op_b   = {imm, 16'h0000};
        d_wreg   = 1'b1;
        d_wraddr = rt;
      end
      6'h23, 6'h24: begin
        d_op_b     = imm_s;
        d_wreg     = 1'b1;
        d_wraddr   = rt;
        d_mem_rd   = 1'b1;
        d_mem_byte = (opcode == 6'h24);
        uses_rs    = 1'b1;
      end
      6'h2B: begin
        d_op_b   = imm_s;
        d_mem_wr = 1'b1;
        uses_rs  = 1'b1;
        uses_rt  = 1'b1;
      end
      6'h04, 6'h05: begin
        uses_rs  = 1'b1;
        uses_rt  = 1'b1;
        br_taken = (opcode == 6'h04) ? (rs_val == rt_val) : (rs_val != rt_val);
      end
      6'h06: begin
        uses_rs  = 1'b1;
        br_taken = rs_val[31] | (rs_val == 32'd0);
      end
      6'h02, 6'h03: begin
        br_taken  = 1'b1;
        br_target = {pc4[31:28], if_inst[25:0], 2'b00};
        if (opcode == 6'h03) begin
          d_alu    = ALU_PASSB;
          d_op_b   = (DELAY_SLOT != 0) ? pc8 : pc4;
          d_wreg   = 1'b1;
          d_wraddr = LINK_ADDR;
        end
      end
      default: d_illegal = 1'b1;
    endcase
  end

  logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt, raw, hazard, accept;

  assign ex_hit_rs  = ex_fwd_wreg  && ex_fwd_addr  != 5'd0 && ex_fwd_addr  == rs;
  assign ex_hit_rt  = ex_fwd_wreg  && ex_fwd_addr  != 5'd0 && ex_fwd_addr  == rt;
  assign mem_hit_rs = mem_fwd_wreg && mem_fwd_addr != 5'd0 && mem_fwd_addr == rs;
  assign mem_hit_rt = mem_fwd_wreg && mem_fwd_addr != 5'd0 && mem_fwd_addr == rt;

  // With forwarding only an EX load blocks; without it any pending producer does.
  assign raw = (FWD_EN != 0)
             ? (ex_fwd_load && ((uses_rs && ex_hit_rs) || (uses_rt && ex_hit_rt)))
             : ((uses_rs && (ex_hit_rs || mem_hit_rs)) || (uses_rt && (ex_hit_rt || mem_hit_rt)));

  // A slot being flushed is discarded anyway, so it never waits on operands.
  assign hazard   = if_valid && (state != S_FLUSH) && raw;
  assign id_ready = ex_ready && !hazard;
  assign accept   = if_valid && id_ready;

  // Issue registers, redirect pulse and the RUN/STALL/FLUSH sequencing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_RUN;
      ex_valid       <= 1'b0;
      ex_alu_op      <= 4'd0;
      ex_op_a        <= 32'd0;
      ex_op_b        <= 32'd0;
      ex_wreg        <= 1'b0;
      ex_wraddr      <= 5'd0;
      ex_mem_rd      <= 1'b0;
      ex_mem_wr      <= 1'b0;
      ex_mem_byte    <= 1'b0;
      ex_store_data  <= 32'd0;
      ex_illegal     <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
    end else begin
      redirect_valid <= 1'b0;
      if (ex_ready) begin
        if (accept && state != S_FLUSH) begin
          ex_valid      <= 1'b1;
          ex_alu_op     <= d_alu;
          ex_op_a       <= d_op_a;
          ex_op_b       <= d_op_b;
          ex_wreg       <= d_wreg;
          ex_wraddr     <= d_wraddr;
          ex_mem_rd     <= d_mem_rd;
          ex_mem_wr     <= d_mem_wr;
          ex_mem_byte   <= d_mem_byte;
          ex_store_data <= rt_val;
          ex_illegal    <= d_illegal;
          if (br_taken) begin
            redirect_valid <= 1'b1;
            redirect_pc    <= br_target;
            state          <= (DELAY_SLOT != 0) ? S_RUN : S_FLUSH;
          end else begin
            state <= S_RUN;
          end
        end else begin
          ex_valid      <= 1'b0;
          ex_alu_op     <= 4'd0;
          ex_op_a       <= 32'd0;
          ex_op_b       <= 32'd0;
          ex_wreg       <= 1'b0;
          ex_wraddr     <= 5'd0;
          ex_mem_rd     <= 1'b0;
          ex_mem_wr     <= 1'b0;
          ex_mem_byte   <= 1'b0;
          ex_store_data <= 32'd0;
          ex_illegal    <= 1'b0;
          if (accept)
            state <= S_RUN;
          else if (hazard)
            state <= S_STALL;
          else if (state == S_STALL)
            state <= S_RUN;
        end
      end
    end
  end

endmodule

// File: tb/tb_decode_pipe.sv
// Directed bench for decode_pipe: a default build (delay slot, forwarding)
// and an alternate build (no delay slot, no forwarding) share one stimulus.
module tb_decode_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_inst, if_pc;
  logic [31:0] reg1_data, reg2_data;
  logic        ex_fwd_wreg, ex_fwd_load;
  logic [4:0]  ex_fwd_addr;
  logic [31:0] ex_fwd_data;
  logic        mem_fwd_wreg;
  logic [4:0]  mem_fwd_addr;
  logic [31:0] mem_fwd_data;
  logic        ex_ready;

  logic        d_id_ready, d_ex_valid, d_wreg, d_mem_rd, d_mem_wr, d_mem_byte, d_illegal, d_redir;
  logic [4:0]  d_r1, d_r2, d_wraddr;
  logic [3:0]  d_alu;
  logic [31:0] d_op_a, d_op_b, d_store, d_redir_pc;

  logic        a_id_ready, a_ex_valid, a_wreg, a_mem_rd, a_mem_wr, a_mem_byte, a_illegal, a_redir;
  logic [4:0]  a_r1, a_r2, a_wraddr;
  logic [3:0]  a_alu;
  logic [31:0] a_op_a, a_op_b, a_store, a_redir_pc;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decode_pipe u_dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
    .id_ready(d_id_ready), .reg1_addr(d_r1), .reg2_addr(d_r2),
    .reg1_data(reg1_data), .reg2_data(reg2_data),
    .ex_fwd_wreg(ex_fwd_wreg), .ex_fwd_load(ex_fwd_load), .ex_fwd_addr(ex_fwd_addr),
    .ex_fwd_data(ex_fwd_data), .mem_fwd_wreg(mem_fwd_wreg), .mem_fwd_addr(mem_fwd_addr),
    .mem_fwd_data(mem_fwd_data), .ex_ready(ex_ready), .ex_valid(d_ex_valid),
    .ex_alu_op(d_alu), .ex_op_a(d_op_a), .ex_op_b(d_op_b), .ex_wreg(d_wreg),
    .ex_wraddr(d_wraddr), .ex_mem_rd(d_mem_rd), .ex_mem_wr(d_mem_wr),
    .ex_mem_byte(d_mem_byte), .ex_store_data(d_store), .ex_illegal(d_illegal),
    .redirect_valid(d_redir), .redirect_pc(d_redir_pc)
  );

  decode_pipe #(.DELAY_SLOT(0), .FWD_EN(0), .LINK_REG(31)) u_alt (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
    .id_ready(a_id_ready), .reg1_addr(a_r1), .reg2_addr(a_r2),
    .reg1_data(reg1_data), .reg2_data(reg2_data),
    .ex_fwd_wreg(ex_fwd_wreg), .ex_fwd_load(ex_fwd_load), .ex_fwd_addr(ex_fwd_addr),
    .ex_fwd_data(ex_fwd_data), .mem_fwd_wreg(mem_fwd_wreg), .mem_fwd_addr(mem_fwd_addr),
    .mem_fwd_data(mem_fwd_data), .ex_ready(ex_ready), .ex_valid(a_ex_valid),
    .ex_alu_op(a_alu), .ex_op_a(a_op_a), .ex_op_b(a_op_b), .ex_wreg(a_wreg),
    .ex_wraddr(a_wraddr), .ex_mem_rd(a_mem_rd), .ex_mem_wr(a_mem_wr),
    .ex_mem_byte(a_mem_byte), .ex_store_data(a_store), .ex_illegal(a_illegal),
    .redirect_valid(a_redir), .redirect_pc(a_redir_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic clr_fwd;
    ex_fwd_wreg  = 1'b0;
    ex_fwd_load  = 1'b0;
    ex_fwd_addr  = 5'd0;
    ex_fwd_data  = 32'd0;
    mem_fwd_wreg = 1'b0;
    mem_fwd_addr = 5'd0;
    mem_fwd_data = 32'd0;
  endtask

  task automatic pulse_rst;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] r_enc(input logic [4:0] s, input logic [4:0] t,
                                        input logic [4:0] d, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, s, t, d, sh, fn};
  endfunction

  function automatic logic [31:0] i_enc(input logic [5:0] op, input logic [4:0] s,
                                        input logic [4:0] t, input logic [15:0] im);
    return {op, s, t, im};
  endfunction

  initial begin
    rst = 1'b1; ex_ready = 1'b1; if_valid = 1'b0; if_inst = 32'd0; if_pc = 32'd0;
    reg1_data = 32'd0; reg2_data = 32'd0;
    clr_fwd();
    tick(); tick();
    chk("rst_valid", 32'(d_ex_valid), 0);
    chk("rst_redir", 32'(d_redir), 0);
    chk("rst_op_a", d_op_a, 0);
    rst = 1'b0;
    settle();
    chk("rst_id_ready", 32'(d_id_ready), 1);

    // forwarding priority
    ex_fwd_wreg = 1'b1; ex_fwd_addr = 5'd1; ex_fwd_data = 32'h10;
    mem_fwd_wreg = 1'b1; mem_fwd_addr = 5'd2; mem_fwd_data = 32'h20;
    reg1_data = 32'hFF; reg2_data = 32'hFF;
    if_valid = 1'b1; if_inst = r_enc(5'd1, 5'd2, 5'd3, 5'd0, 6'h21); if_pc = 32'h200;
    settle();
    chk("raddr1", 32'(d_r1), 1);
    chk("raddr2", 32'(d_r2), 2);
    chk("fwd_ready", 32'(d_id_ready), 1);
    tick();
    chk("fwd_valid", 32'(d_ex_valid), 1);
    chk("fwd_ex_a", d_op_a, 32'h10);
    chk("fwd_mem_b", d_op_b, 32'h20);
    chk("fwd_alu", 32'(d_alu), 0);
    chk("fwd_wraddr", 32'(d_wraddr), 3);
    chk("fwd_wreg", 32'(d_wreg), 1);
    mem_fwd_addr = 5'd1;
    tick();
    chk("fwd_ex_wins", d_op_a, 32'h10);
    chk("fwd_rf_b", d_op_b, 32'hFF);
    if_inst = r_enc(5'd0, 5'd2, 5'd3, 5'd0, 6'h21);
    ex_fwd_addr = 5'd0; mem_fwd_addr = 5'd0;
    tick();
    chk("fwd_r0", d_op_a, 0);
    chk("fwd_r0_b", d_op_b, 32'hFF);
    clr_fwd();

    // immediates, shifts, memory
    if_inst = i_enc(6'h0D, 5'd1, 5'd6, 16'h8001);
    tick();
    chk("ori_a", d_op_a, 32'hFF);
    chk("ori_zext", d_op_b, 32'h0000_8001);
    chk("ori_alu", 32'(d_alu), 3);
    chk("ori_wraddr", 32'(d_wraddr), 6);
    if_inst = i_enc(6'h09, 5'd1, 5'd6, 16'h8001);
    tick();
    chk("addiu_sext", d_op_b, 32'hFFFF_8001);
    chk("addiu_alu", 32'(d_alu), 0);
    if_inst = i_enc(6'h0F, 5'd0, 5'd7, 16'h1234);
    tick();
    chk("lui_b", d_op_b, 32'h1234_0000);
    chk("lui_alu", 32'(d_alu), 11);
    if_inst = r_enc(5'd0, 5'd2, 5'd8, 5'd5, 6'h00);
    tick();
    chk("sll_a", d_op_a, 5);
    chk("sll_b", d_op_b, 32'hFF);
    chk("sll_alu", 32'(d_alu), 8);
    reg1_data = 32'h0000_0123;
    if_inst = r_enc(5'd1, 5'd2, 5'd8, 5'd0, 6'h07);
    tick();
    chk("srav_a", d_op_a, 32'h03);
    chk("srav_alu", 32'(d_alu), 10);
    reg1_data = 32'hFF;
    if_inst = i_enc(6'h23, 5'd1, 5'd9, 16'h0004);
    tick();
    chk("lw_rd", 32'(d_mem_rd), 1);
    chk("lw_b", d_op_b, 4);
    chk("lw_wraddr", 32'(d_wraddr), 9);
    chk("lw_byte", 32'(d_mem_byte), 0);
    if_inst = i_enc(6'h24, 5'd1, 5'd9, 16'h0004);
    tick();
    chk("lbu_byte", 32'(d_mem_byte), 1);
    reg2_data = 32'hCAFE;
    if_inst = i_enc(6'h2B, 5'd1, 5'd9, 16'hFFFC);
    tick();
    chk("sw_wr", 32'(d_mem_wr), 1);
    chk("sw_wreg", 32'(d_wreg), 0);
    chk("sw_data", d_store, 32'hCAFE);
    chk("sw_b", d_op_b, 32'hFFFF_FFFC);

    // load-use, forwarding build
    ex_fwd_wreg = 1'b1; ex_fwd_load = 1'b1; ex_fwd_addr = 5'd4; ex_fwd_data = 32'hDEAD;
    if_inst = r_enc(5'd4, 5'd4, 5'd5, 5'd0, 6'h20);
    settle();
    chk("lu_ready0", 32'(d_id_ready), 0);
    tick();
    chk("lu_bubble", 32'(d_ex_valid), 0);
    ex_fwd_wreg = 1'b0; ex_fwd_load = 1'b0;
    mem_fwd_wreg = 1'b1; mem_fwd_addr = 5'd4; mem_fwd_data = 32'h44;
    settle();
    chk("lu_ready1", 32'(d_id_ready), 1);
    tick();
    chk("lu_issue", 32'(d_ex_valid), 1);
    chk("lu_a", d_op_a, 32'h44);
    chk("lu_b", d_op_b, 32'h44);
    if_valid = 1'b0;
    clr_fwd();
    tick();
    chk("idle_valid", 32'(d_ex_valid), 0);

    // load-use, no-forwarding build: stalls until MEM also retires
    pulse_rst();
    reg1_data = 32'h55; reg2_data = 32'h55;
    ex_fwd_wreg = 1'b1; ex_fwd_load = 1'b1; ex_fwd_addr = 5'd4;
    if_valid = 1'b1; if_inst = r_enc(5'd4, 5'd4, 5'd5, 5'd0, 6'h20);
    settle();
    chk("nf_ready0", 32'(a_id_ready), 0);
    tick();
    chk("nf_bubble0", 32'(a_ex_valid), 0);
    ex_fwd_wreg = 1'b0; ex_fwd_load = 1'b0;
    mem_fwd_wreg = 1'b1; mem_fwd_addr = 5'd4; mem_fwd_data = 32'h44;
    settle();
    chk("nf_ready1", 32'(a_id_ready), 0);
    tick();
    chk("nf_bubble1", 32'(a_ex_valid), 0);
    clr_fwd();
    settle();
    chk("nf_ready2", 32'(a_id_ready), 1);
    tick();
    chk("nf_issue", 32'(a_ex_valid), 1);
    chk("nf_a", a_op_a, 32'h55);
    if_valid = 1'b0;
    tick();

    // branches
    pulse_rst();
    reg1_data = 32'h7; reg2_data = 32'h7;
    if_valid = 1'b1; if_inst = i_enc(6'h04, 5'd1, 5'd1, 16'h0003); if_pc = 32'h100;
    tick();
    chk("beq_redir", 32'(d_redir), 1);
    chk("beq_pc", d_redir_pc, 32'h110);
    chk("beq_wreg", 32'(d_wreg), 0);
    chk("beq_valid", 32'(d_ex_valid), 1);
    chk("beq_alt_redir", 32'(a_redir), 1);
    chk("beq_alt_pc", a_redir_pc, 32'h110);
    if_inst = i_enc(6'h0D, 5'd0, 5'd2, 16'h0005); if_pc = 32'h104;
    settle();
    chk("flush_ready", 32'(a_id_ready), 1);
    tick();
    chk("slot_pulse_end", 32'(d_redir), 0);
    chk("slot_valid", 32'(d_ex_valid), 1);
    chk("slot_b", d_op_b, 5);
    chk("slot_alt_bubble", 32'(a_ex_valid), 0);
    chk("slot_alt_redir", 32'(a_redir), 0);
    if_inst = i_enc(6'h05, 5'd1, 5'd1, 16'h0003); if_pc = 32'h108;
    tick();
    chk("bne_nt", 32'(d_redir), 0);
    chk("bne_valid", 32'(d_ex_valid), 1);
    chk("alt_run_again", 32'(a_ex_valid), 1);
    reg1_data = 32'h8000_0000;
    if_inst = i_enc(6'h06, 5'd1, 5'd0, 16'hFFFE); if_pc = 32'h200;
    tick();
    chk("blez_redir", 32'(d_redir), 1);
    chk("blez_pc", d_redir_pc, 32'h1FC);
    if_inst = i_enc(6'h0D, 5'd0, 5'd2, 16'h0005); if_pc = 32'h204;
    tick();
    chk("blez_alt_flush", 32'(a_ex_valid), 0);
    if_inst = {6'h03, 26'h004_0000}; if_pc = 32'h0040_0010;
    tick();
    chk("jal_redir", 32'(d_redir), 1);
    chk("jal_pc", d_redir_pc, 32'h0010_0000);
    chk("jal_wraddr", 32'(d_wraddr), 31);
    chk("jal_wreg", 32'(d_wreg), 1);
    chk("jal_b", d_op_b, 32'h0040_0018);
    chk("jal_alu", 32'(d_alu), 11);
    chk("jal_alt_b", a_op_b, 32'h0040_0014);
    reg1_data = 32'h0000_3000;
    if_inst = r_enc(5'd1, 5'd0, 5'd0, 5'd0, 6'h08); if_pc = 32'h0010_0000;
    tick();
    chk("jr_redir", 32'(d_redir), 1);
    chk("jr_pc", d_redir_pc, 32'h3000);
    if_valid = 1'b0;
    tick();

    // reset while stalled drops the held instruction
    pulse_rst();
    ex_fwd_wreg = 1'b1; ex_fwd_load = 1'b1; ex_fwd_addr = 5'd4;
    if_valid = 1'b1; if_inst = r_enc(5'd4, 5'd4, 5'd5, 5'd0, 6'h20);
    tick();
    chk("stall_bubble", 32'(a_ex_valid), 0);
    rst = 1'b1;
    clr_fwd();
    if_valid = 1'b0;
    tick();
    rst = 1'b0;
    settle();
    chk("stall_rst_ready", 32'(a_id_ready), 1);
    tick();
    chk("stall_rst_drop", 32'(a_ex_valid), 0);

    // backpressure then illegal
    reg1_data = 32'h11; reg2_data = 32'h22;
    if_valid = 1'b1; if_inst = r_enc(5'd1, 5'd2, 5'd3, 5'd0, 6'h21); if_pc = 32'h300;
    tick();
    chk("bp_pre_a", d_op_a, 32'h11);
    ex_ready = 1'b0;
    reg1_data = 32'h99;
    if_inst = r_enc(5'd1, 5'd2, 5'd4, 5'd0, 6'h26);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("bp_ready", 32'(d_id_ready), 0);
      tick();
      chk("bp_hold_a", d_op_a, 32'h11);
      chk("bp_hold_valid", 32'(d_ex_valid), 1);
      chk("bp_hold_wraddr", 32'(d_wraddr), 3);
    end
    ex_ready = 1'b1;
    if_inst = 32'hFC00_0000;
    tick();
    chk("ill_flag", 32'(d_illegal), 1);
    chk("ill_valid", 32'(d_ex_valid), 1);
    chk("ill_wreg", 32'(d_wreg), 0);
    chk("ill_mem_wr", 32'(d_mem_wr), 0);
    chk("ill_mem_rd", 32'(d_mem_rd), 0);
    if_inst = r_enc(5'd1, 5'd2, 5'd3, 5'd0, 6'h01);
    tick();
    chk("ill_funct", 32'(d_illegal), 1);
    chk("ill_funct_wreg", 32'(d_wreg), 0);
    if_inst = r_enc(5'd1, 5'd2, 5'd4, 5'd0, 6'h26);
    tick();
    chk("xor_legal", 32'(d_illegal), 0);
    chk("xor_alu", 32'(d_alu), 4);
    chk("xor_a", d_op_a, 32'h99);

    // asynchronous reset mid-stream
    rst = 1'b1;
    #2;
    chk("arst_valid", 32'(d_ex_valid), 0);
    chk("arst_op_a", d_op_a, 0);
    chk("arst_wreg", 32'(d_wreg), 0);
    chk("arst_redir", 32'(d_redir), 0);
    if_valid = 1'b0;
    tick();
    rst = 1'b0;
    settle();
    chk("arst_ready", 32'(d_id_ready), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
